// File: rtl/ddr2_user_arbiter_pkg.sv
// Shared definitions for the two-port DDR2 user-interface arbiter:
// controller command codes, arbiter FSM states and parameter defaults.
package ddr2_user_arbiter_pkg;

   localparam int unsigned AddrWDefault    = 23;
   localparam int unsigned BurstIncDefault = 4;

   typedef enum logic [3:0] {
      CmdNop   = 4'b0000,
      CmdInit  = 4'b0010,
      CmdWrite = 4'b0100,
      CmdRead  = 4'b0110
   } cmd_e;

   typedef enum logic [3:0] {
      StInit,
      StInitWait,
      StIdle,
      StRefresh,
      StCmd,
      StXfer,
      StBdone,
      StRdDrain,
      StAckLow
   } state_e;

endpackage

// File: rtl/ddr2_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port not granted last wins.
// The pointer only moves when the caller accepts the grant.
module ddr2_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic       gnt_any,
   output logic       gnt_sel
);

   logic last_q;

   always_comb begin
      gnt_any = |req;
      if (req == 2'b11) gnt_sel = ~last_q;
      else              gnt_sel = req[1];
   end

   // Reset to port 1 so that port 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         last_q <= 1'b1;
      else if (update) last_q <= gnt_sel;
   end

endmodule

// File: rtl/ddr2_user_arbiter.sv
// Two-port user arbiter in front of a DDR2 controller user interface:
// runs controller init, yields to refresh, and sequences one burst per grant.
module ddr2_user_arbiter
   import ddr2_user_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = AddrWDefault,
   parameter int unsigned BURST_INC = BurstIncDefault
) (
   input  logic              clk_int,
   input  logic              sys_rst,
   input  logic              init_val,
   input  logic              user_cmd_ack,
   input  logic              auto_ref_req,
   input  logic              ar_done,
   input  logic              user_data_valid,
   output logic [3:0]        user_command_register,
   output logic [ADDR_W-1:0] user_input_address,
   output logic [1:0]        user_bank_address,
   output logic              burst_done,
   input  logic              p0_req,
   input  logic              p0_wr,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [1:0]        p0_bank,
   input  logic [3:0]        p0_len,
   input  logic              p1_req,
   input  logic              p1_wr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [1:0]        p1_bank,
   input  logic [3:0]        p1_len,
   output logic              p0_gnt,
   output logic              p0_wdata_req,
   output logic              p0_rdata_valid,
   output logic              p0_done,
   output logic              p1_gnt,
   output logic              p1_wdata_req,
   output logic              p1_rdata_valid,
   output logic              p1_done
);

   state_e            state_q, state_d;
   cmd_e              cmd_q, cmd_d;
   logic              sel_q, sel_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        bank_q, bank_d;
   logic [3:0]        len_q, len_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [4:0]        rcnt_q, rcnt_d;

   logic gnt_any, gnt_sel, arb_update;
   logic active, rd_full, beat, done_pulse;

   ddr2_rr_arbiter2 u_rr (
      .clk     (clk_int),
      .rst     (sys_rst),
      .req     ({p1_req, p0_req}),
      .update  (arb_update),
      .gnt_any (gnt_any),
      .gnt_sel (gnt_sel)
   );

   assign active  = state_q inside {StCmd, StXfer, StBdone, StRdDrain, StAckLow};
   assign rd_full = (rcnt_q == ({1'b0, len_q} + 5'd1));
   assign beat    = user_data_valid && active && !wr_q && !rd_full;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      bank_d     = bank_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      rcnt_d     = beat ? rcnt_q + 5'd1 : rcnt_q;
      arb_update = 1'b0;
      done_pulse = 1'b0;

      unique case (state_q)
         StInit:     state_d = StInitWait;
         StInitWait: if (init_val) state_d = StIdle;
         StIdle: begin
            if (auto_ref_req) begin
               state_d = StRefresh;
            end else if (gnt_any) begin
               arb_update = 1'b1;
               sel_d      = gnt_sel;
               wr_d       = gnt_sel ? p1_wr   : p0_wr;
               addr_d     = gnt_sel ? p1_addr : p0_addr;
               bank_d     = gnt_sel ? p1_bank : p0_bank;
               len_d      = gnt_sel ? p1_len  : p0_len;
               cnt_d      = 4'd0;
               rcnt_d     = 5'd0;
               state_d    = StCmd;
            end
         end
         StRefresh:  if (ar_done) state_d = StIdle;
         StCmd:      if (user_cmd_ack) state_d = StXfer;
         StXfer: begin
            if (cnt_q == len_q) begin
               cnt_d   = 4'd0;
               state_d = StBdone;
            end else begin
               cnt_d = cnt_q + 4'd1;
               // Two user words share one column step.
               if (cnt_q[0]) addr_d = addr_q + ADDR_W'(BURST_INC);
            end
         end
         StBdone: begin
            if (cnt_q[0]) begin
               cnt_d = 4'd0;
               if (!wr_q && (rcnt_d != ({1'b0, len_q} + 5'd1))) state_d = StRdDrain;
               else                                             state_d = StAckLow;
            end else begin
               cnt_d = 4'd1;
            end
         end
         StRdDrain:  if (rcnt_d == ({1'b0, len_q} + 5'd1)) state_d = StAckLow;
         StAckLow: begin
            if (!user_cmd_ack) begin
               done_pulse = 1'b1;
               state_d    = StIdle;
            end
         end
         default:    state_d = StInit;
      endcase

      // Command is registered so it reads NOP while reset is held.
      if (state_q == StInit)                    cmd_d = CmdInit;
      else if (state_d inside {StCmd, StXfer}) cmd_d = wr_d ? CmdWrite : CmdRead;
      else                                     cmd_d = CmdNop;
   end

   always_ff @(posedge clk_int or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= StInit;
         cmd_q   <= CmdNop;
         sel_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         bank_q  <= 2'd0;
         len_q   <= 4'd0;
         cnt_q   <= 4'd0;
         rcnt_q  <= 5'd0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         sel_q   <= sel_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         bank_q  <= bank_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign user_command_register = cmd_q;
   assign user_input_address    = addr_q;
   assign user_bank_address     = bank_q;
   assign burst_done            = (state_q == StBdone);

   assign p0_gnt         = active && !sel_q;
   assign p1_gnt         = active && sel_q;
   assign p0_wdata_req   = (state_q == StXfer) && wr_q && !sel_q;
   assign p1_wdata_req   = (state_q == StXfer) && wr_q && sel_q;
   assign p0_rdata_valid = beat && !sel_q;
   assign p1_rdata_valid = beat && sel_q;
   assign p0_done        = done_pulse && !sel_q;
   assign p1_done        = done_pulse && sel_q;

endmodule

// File: tb/tb_ddr2_user_arbiter.sv
// Directed bench for ddr2_user_arbiter; the bench plays the DDR2 controller
// and both requesters, checking against hand-computed values.
module tb_ddr2_user_arbiter;

   logic        clk_int = 1'b0;
   logic        sys_rst = 1'b1;
   logic        init_val = 1'b0, user_cmd_ack = 1'b0, auto_ref_req = 1'b0;
   logic        ar_done = 1'b0, user_data_valid = 1'b0;
   logic [3:0]  user_command_register;
   logic [22:0] user_input_address;
   logic [1:0]  user_bank_address;
   logic        burst_done;
   logic        p0_req = 1'b0, p0_wr = 1'b0, p1_req = 1'b0, p1_wr = 1'b0;
   logic [22:0] p0_addr = '0, p1_addr = '0;
   logic [1:0]  p0_bank = '0, p1_bank = '0;
   logic [3:0]  p0_len = '0, p1_len = '0;
   logic        p0_gnt, p0_wdata_req, p0_rdata_valid, p0_done;
   logic        p1_gnt, p1_wdata_req, p1_rdata_valid, p1_done;

   always #5 clk_int = ~clk_int;

   ddr2_user_arbiter dut (
      .clk_int               (clk_int),
      .sys_rst               (sys_rst),
      .init_val              (init_val),
      .user_cmd_ack          (user_cmd_ack),
      .auto_ref_req          (auto_ref_req),
      .ar_done               (ar_done),
      .user_data_valid       (user_data_valid),
      .user_command_register (user_command_register),
      .user_input_address    (user_input_address),
      .user_bank_address     (user_bank_address),
      .burst_done            (burst_done),
      .p0_req                (p0_req),
      .p0_wr                 (p0_wr),
      .p0_addr               (p0_addr),
      .p0_bank               (p0_bank),
      .p0_len                (p0_len),
      .p1_req                (p1_req),
      .p1_wr                 (p1_wr),
      .p1_addr               (p1_addr),
      .p1_bank               (p1_bank),
      .p1_len                (p1_len),
      .p0_gnt                (p0_gnt),
      .p0_wdata_req          (p0_wdata_req),
      .p0_rdata_valid        (p0_rdata_valid),
      .p0_done               (p0_done),
      .p1_gnt                (p1_gnt),
      .p1_wdata_req          (p1_wdata_req),
      .p1_rdata_valid        (p1_rdata_valid),
      .p1_done               (p1_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Results of the last transfer served by the controller model.
   int          s_cmd, s_g0, s_g1, s_bank, s_xfer, s_wreq, s_rv0, s_rv1;
   int          s_bd, s_done0, s_done1, s_other;
   logic [22:0] addr_log[$];

   task automatic serve(input bit drop_req, input int nbeats, input int beat_start,
                        input int ref_at);
      bit found = 1'b0;
      bit drop_ack = 1'b0;
      int sent = 0;
      int post = 0;
      {s_cmd, s_g0, s_g1, s_bank, s_xfer, s_wreq, s_rv0, s_rv1} = '0;
      {s_bd, s_done0, s_done1, s_other} = '0;
      addr_log.delete();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_int);
         if (user_command_register != 4'h0) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         check_eq("cmd_timeout", 32'd0, 32'd1);
         return;
      end
      s_cmd  = int'(user_command_register);
      s_g0   = int'(p0_gnt);
      s_g1   = int'(p1_gnt);
      s_bank = int'(user_bank_address);
      @(posedge clk_int); #1;
      if (drop_req) begin
         p0_req = 1'b0;
         p1_req = 1'b0;
      end
      @(posedge clk_int); #1;
      user_cmd_ack = 1'b1;
      for (int n = 0; n < 80; n++) begin
         @(posedge clk_int); #1;
         if (drop_ack) user_cmd_ack = 1'b0;
         if (n == ref_at) auto_ref_req = 1'b1;
         user_data_valid = (n >= beat_start) && (sent < nbeats);
         if (user_data_valid) sent++;
         @(negedge clk_int);
         if (user_command_register != 4'h0 && !burst_done && s_bd == 0) begin
            s_xfer++;
            addr_log.push_back(user_input_address);
         end
         s_wreq  += int'(p0_wdata_req | p1_wdata_req);
         s_rv0   += int'(p0_rdata_valid);
         s_rv1   += int'(p1_rdata_valid);
         s_bd    += int'(burst_done);
         if (s_done0 + s_done1 == 0)
            s_other += s_g1 != 0 ? int'(p0_gnt | p0_wdata_req | p0_rdata_valid | p0_done)
                                 : int'(p1_gnt | p1_wdata_req | p1_rdata_valid | p1_done);
         s_done0 += int'(p0_done);
         s_done1 += int'(p1_done);
         if (s_bd == 2) drop_ack = 1'b1;
         if (s_done0 + s_done1 > 0) post++;
         if (post == 3) break;
      end
      user_data_valid = 1'b0;
      user_cmd_ack    = 1'b0;
      if (s_done0 + s_done1 == 0) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      @(posedge clk_int); #1;
      @(posedge clk_int); #1;
      sys_rst = 1'b0;
   endtask

   int init_cnt, gnt_cnt, bad_cmd;
   int seq[4];

   initial begin
      // Reset state
      repeat (3) @(posedge clk_int);
      @(negedge clk_int);
      check_eq("rst_cmd", 32'(user_command_register), 32'h0);
      check_eq("rst_addr", 32'(user_input_address), 32'h0);
      check_eq("rst_bank", 32'(user_bank_address), 32'h0);
      check_eq("rst_bdone", 32'(burst_done), 32'h0);
      check_eq("rst_port_outs", 32'({p0_gnt, p0_wdata_req, p0_rdata_valid, p0_done,
                                      p1_gnt, p1_wdata_req, p1_rdata_valid, p1_done}), 32'h0);

      // Init with a pending p0 write: no grant until init_val
      p0_wr = 1'b1; p0_addr = 23'h100; p0_bank = 2'd2; p0_len = 4'd3; p0_req = 1'b1;
      @(posedge clk_int); #1;
      sys_rst = 1'b0;
      {init_cnt, gnt_cnt, bad_cmd} = '0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_int);
         init_cnt += int'(user_command_register == 4'b0010);
         gnt_cnt  += int'(p0_gnt | p1_gnt);
         bad_cmd  += int'(user_command_register != 4'b0010 && user_command_register != 4'h0);
      end
      check_eq("init_cycles", 32'(init_cnt), 32'd1);
      check_eq("grant_before_init", 32'(gnt_cnt), 32'd0);
      check_eq("cmd_before_init", 32'(bad_cmd), 32'd0);
      @(posedge clk_int); #1;
      init_val = 1'b1;

      // p0 write 0x100 len 3, request dropped after grant
      serve(1'b1, 0, 0, -1);
      check_eq("w_cmd", 32'(s_cmd), 32'h4);
      check_eq("w_gnt", 32'({s_g1[0], s_g0[0]}), 32'b01);
      check_eq("w_bank", 32'(s_bank), 32'd2);
      check_eq("w_xfer", 32'(s_xfer), 32'd4);
      check_eq("w_addr0", 32'(addr_log[0]), 32'h100);
      check_eq("w_addr1", 32'(addr_log[1]), 32'h100);
      check_eq("w_addr2", 32'(addr_log[2]), 32'h104);
      check_eq("w_addr3", 32'(addr_log[3]), 32'h104);
      check_eq("w_wreq", 32'(s_wreq), 32'd4);
      check_eq("w_bdone", 32'(s_bd), 32'd2);
      check_eq("w_done0", 32'(s_done0), 32'd1);
      check_eq("w_done1", 32'(s_done1), 32'd0);
      check_eq("w_other_port", 32'(s_other), 32'd0);

      // Round-robin ties after a fresh reset: p0, p1, p0, p1
      do_reset();
      p0_wr = 1'b1; p0_addr = 23'h10; p0_bank = 2'd0; p0_len = 4'd0;
      p1_wr = 1'b0; p1_addr = 23'h20; p1_bank = 2'd1; p1_len = 4'd0;
      p0_req = 1'b1; p1_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         serve(k == 3, 1, 0, -1);
         seq[k] = s_g1;
         check_eq("rr_xfer_len0", 32'(s_xfer), 32'd1);
         check_eq("rr_other_port", 32'(s_other), 32'd0);
         if (k == 1) begin
            check_eq("rr_rd_cmd", 32'(s_cmd), 32'h6);
            check_eq("rr_rd_addr", 32'(addr_log[0]), 32'h20);
            check_eq("rr_rd_beats", 32'(s_rv1), 32'd1);
         end
      end
      check_eq("rr_grant0", 32'(seq[0]), 32'd0);
      check_eq("rr_grant1", 32'(seq[1]), 32'd1);
      check_eq("rr_grant2", 32'(seq[2]), 32'd0);
      check_eq("rr_grant3", 32'(seq[3]), 32'd1);

      // p1 read len 7 with refresh raised mid-transfer; beats run past BDONE
      p1_wr = 1'b0; p1_addr = 23'h200; p1_bank = 2'd1; p1_len = 4'd7; p1_req = 1'b1;
      serve(1'b1, 8, 3, 2);
      check_eq("rd_cmd", 32'(s_cmd), 32'h6);
      check_eq("rd_gnt1", 32'(s_g1), 32'd1);
      check_eq("rd_xfer", 32'(s_xfer), 32'd8);
      check_eq("rd_addr_last", 32'(addr_log[7]), 32'h20c);
      check_eq("rd_beats1", 32'(s_rv1), 32'd8);
      check_eq("rd_beats0", 32'(s_rv0), 32'd0);
      check_eq("rd_done1", 32'(s_done1), 32'd1);
      p0_wr = 1'b1; p0_addr = 23'h40; p0_len = 4'd0; p0_req = 1'b1;
      {gnt_cnt, bad_cmd} = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_int);
         gnt_cnt += int'(p0_gnt | p1_gnt);
         bad_cmd += int'(user_command_register != 4'h0);
      end
      check_eq("ref_no_grant", 32'(gnt_cnt), 32'd0);
      check_eq("ref_nop", 32'(bad_cmd), 32'd0);
      @(posedge clk_int); #1;
      auto_ref_req = 1'b0; ar_done = 1'b1;
      @(posedge clk_int); #1;
      ar_done = 1'b0;
      serve(1'b1, 0, 0, -1);
      check_eq("post_ref_gnt0", 32'(s_g0), 32'd1);
      check_eq("post_ref_addr", 32'(addr_log[0]), 32'h40);

      // Address wrap at the top of the space
      p0_addr = 23'h7ffffe; p0_len = 4'd3; p0_req = 1'b1;
      serve(1'b1, 0, 0, -1);
      check_eq("wrap_xfer", 32'(s_xfer), 32'd4);
      check_eq("wrap_addr1", 32'(addr_log[1]), 32'h7ffffe);
      check_eq("wrap_addr2", 32'(addr_log[2]), 32'h000002);
      check_eq("wrap_addr3", 32'(addr_log[3]), 32'h000002);

      // Reset in the middle of a p1 read burst
      p1_wr = 1'b0; p1_addr = 23'h300; p1_bank = 2'd3; p1_len = 4'd15; p1_req = 1'b1;
      init_cnt = 0;
      for (int i = 0; i < 40 && init_cnt == 0; i++) begin
         @(negedge clk_int);
         if (user_command_register != 4'h0) init_cnt = 1;
      end
      check_eq("mid_cmd_seen", 32'(init_cnt), 32'd1);
      @(posedge clk_int); #1;
      user_cmd_ack = 1'b1;
      repeat (3) @(posedge clk_int);
      #1;
      sys_rst = 1'b1;
      #1;
      check_eq("mid_rst_cmd", 32'(user_command_register), 32'h0);
      check_eq("mid_rst_addr", 32'(user_input_address), 32'h0);
      check_eq("mid_rst_bank", 32'(user_bank_address), 32'h0);
      check_eq("mid_rst_gnt", 32'({p1_gnt, p0_gnt, burst_done}), 32'h0);
      user_cmd_ack = 1'b0; p1_req = 1'b0;
      @(posedge clk_int); #1;
      sys_rst = 1'b0;
      init_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_int);
         init_cnt += int'(user_command_register == 4'b0010);
      end
      check_eq("mid_rst_reinit", 32'(init_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr2_user_arbiter.md
DDR2_USER_ARBITER -- requirements
Module: ddr2_user_arbiter

Interface
REQ-001 Parameter ADDR_W, default 23, width of user_input_address (row + column bits).
REQ-002 Parameter BURST_INC, default 4, column increment applied per two user words.
REQ-003 Port clk_int  in  1  single clock for all logic.
REQ-004 Port sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 Port init_val  in  1  controller initialisation complete.
REQ-006 Port user_cmd_ack  in  1  controller command acknowledge.
REQ-007 Port auto_ref_req  in  1  controller refresh pending.
REQ-008 Port ar_done  in  1  controller refresh complete pulse.
REQ-009 Port user_data_valid  in  1  controller read word valid.
REQ-010 Port user_command_register  out  4  command: NOP 0000, INIT 0010, WRITE 0100, READ 0110.
REQ-011 Port user_input_address  out  ADDR_W  command address.
REQ-012 Port user_bank_address  out  2  command bank.
REQ-013 Port burst_done  out  1  end-of-transfer strobe to controller.
REQ-014 Ports pX_req / pX_wr / pX_addr[ADDR_W] / pX_bank[2] / pX_len[4]  in, X in {0,1}: request, 1=write, start address, bank, words minus 1.
REQ-015 Ports pX_gnt / pX_wdata_req / pX_rdata_valid / pX_done  out  1, X in {0,1}: granted, write-word request, read-word valid, completion pulse.

Function
REQ-016 FSM states SHALL be INIT, INIT_WAIT, IDLE, REFRESH, CMD, XFER, BDONE, RD_DRAIN, ACK_LOW.
REQ-017 INIT: command INIT for one cycle, then INIT_WAIT until init_val=1, then IDLE.
REQ-018 IDLE: auto_ref_req=1 -> REFRESH (no grant), priority over any request.
REQ-019 REFRESH: command NOP; ar_done=1 -> IDLE.
REQ-020 IDLE with requests and auto_ref_req=0: round-robin grant; both requesting -> port not granted last; after reset port 0 wins ties.
REQ-021 Grant registers addr, bank, len, wr; pX_gnt high from CMD through ACK_LOW, low otherwise.
REQ-022 CMD: command WRITE/READ with registered address/bank held until user_cmd_ack=1, then XFER.
REQ-023 XFER lasts len+1 cycles; address increments by BURST_INC every second cycle, wrapping modulo 2^ADDR_W.
REQ-024 Write: pX_wdata_req high each XFER cycle (len+1 cycles); requester presents data on following cycle.
REQ-025 BDONE: burst_done high exactly 2 cycles, command returns to NOP on first BDONE cycle.
REQ-026 Read: pX_rdata_valid = user_data_valid for granted port from CMD until len+1 beats counted; RD_DRAIN after BDONE waits remaining beats.
REQ-027 ACK_LOW: wait user_cmd_ack=0, pulse pX_done one cycle, return IDLE.
REQ-028 auto_ref_req rising during CMD..ACK_LOW SHALL NOT abort transfer; serviced at next IDLE.
REQ-029 pX_req dropped after grant ignored; transfer completes.
REQ-030 len=0: XFER one cycle, no address increment.
REQ-031 Non-granted port outputs held 0.

Reset
REQ-032 sys_rst=1: FSM -> INIT, command NOP, address/bank 0, burst_done 0, all pX_ outputs 0, round-robin pointer to port 1 (so port 0 wins first).
REQ-033 Reset mid-transfer: immediate abandon; full INIT sequence reissued after release.

Structure
REQ-034 Shared package holds command encodings, FSM state encoding, ADDR_W/BURST_INC defaults.
REQ-035 Sub-module ddr2_rr_arbiter2 (two-way round-robin, grant + pointer update) SHALL be instantiated.

Verification
REQ-036 Reset release, init_val after 50 cycles -> one INIT cycle, NOP, no grant before init_val.
REQ-037 p0 write addr 0x100 len 3, ack 2 cycles after CMD -> addresses 0x100,0x100,0x104,0x104; 4 wdata_req; burst_done 2 cycles; p0_done once.
REQ-038 p0 and p1 request together twice -> grants p0, p1, p0, p1.
REQ-039 auto_ref_req during p1 read len 7 -> read completes with 8 rdata_valid beats, then REFRESH until ar_done, then next grant.
REQ-040 addr 2^23-2, len 3 -> address wraps to 0x000002.
REQ-041 sys_rst during XFER -> outputs to reset values same cycle, INIT reissued.
